controller_modulo: RTL and testbench

Control FSM that drives `datapath_modulo` to compute `Zahl1 mod Zahl2` by repeated subtraction. It issues the datapath's write-back flags, register-transfer selects and ALU mode, reads back the datapath's termination flag `valid_o`, and reports completion to the system. It sits beside `datapath_modulo` in the modulo top level, which wires the two blocks together.

---
 rtl/modulo_pkg.sv | 26 ++
 rtl/ctrl_wait_cnt.sv | 36 +++
 rtl/controller_modulo.sv | 162 ++++++++++++++++
 tb/tb_controller_modulo.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/modulo_pkg.sv
// modulo_pkg: definitions shared by the modulo controller, its wait counter
// and the ALU.
//   - ALU mode codes (ALU_NOP / ALU_SUB / ALU_LT), also decoded by alu_modulo.
//   - state_t: controller state encoding, also driven out on the debug port.
//   - WAIT_W: width of the ALU latency wait counter (ALU_LAT up to 15).
package modulo_pkg;

  localparam logic [2:0] ALU_NOP = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_LT  = 3'd2;

  localparam int unsigned WAIT_W = 4;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_CAPT  = 4'd1,
    ST_LOAD  = 4'd2,
    ST_INIT  = 4'd3,
    ST_CMP   = 4'd4,
    ST_CHECK = 4'd5,
    ST_SUB   = 4'd6,
    ST_DONE  = 4'd7,
    ST_ERR   = 4'd8
  } state_t;

endpackage

// File: rtl/ctrl_wait_cnt.sv
// ctrl_wait_cnt: loadable down-counter that times the ALU latency.
// Ports:
//   clk, rst    - clock, synchronous active-high reset (count cleared to 0)
//   load        - load the count with LAT
//   en          - decrement while non-zero
//   expire      - count is zero; after a load this is LAT enabled cycles later
// Parameter LAT: ALU latency in cycles, 1..15.
module ctrl_wait_cnt
  import modulo_pkg::*;
#(
  parameter int unsigned LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  logic [WAIT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= WAIT_W'(LAT);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - WAIT_W'(1);
    end
  end

  // Stays asserted once the count has run out, so the owning state sees one
  // extra cycle at zero: that cycle is the write-back slot.
  assign expire = (cnt == '0);

endmodule

// File: rtl/controller_modulo.sv
// controller_modulo: control FSM sequencing datapath_modulo to compute
// Zahl1 mod Zahl2 by repeated subtraction.
// Ports:
//   clk, rst                - clock, synchronous active-high reset
//   start_i                 - start request, sampled only in IDLE
//   valid_i                 - datapath termination flag (valid_o)
//   dp_start_o              - datapath operand capture
//   alu_mode_o              - ALU mode (ALU_NOP/ALU_SUB/ALU_LT)
//   wren_*_o                - datapath write-back flags, at most one high
//   erg_to_alu_a_o,
//   Zahl2_to_alu_b_o        - ALU operand selects
//   check_for_termination_o - datapath termination strobe
//   busy_o                  - high in every state except IDLE
//   done_o                  - one-cycle completion pulse, result valid
//   err_o                   - one-cycle timeout pulse
//   dbg_state_o             - current FSM state, for observation only
// Parameters: ALU_LAT (1..15), MAX_ITER (subtraction limit).
// Build option: CTRL_MODULO_TIMEOUT_EN adds the iteration counter and the
// ERR state; without it err_o is constant 0 and Zahl2 = 0 never terminates.
// Every output is decoded from the state and the wait counter only; valid_i
// only steers the CHECK transition.
module controller_modulo
  import modulo_pkg::*;
#(
  parameter int unsigned ALU_LAT  = 2,
  parameter int unsigned MAX_ITER = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       valid_i,
  output logic       dp_start_o,
  output logic [2:0] alu_mode_o,
  output logic       wren_update_Zahlen_o,
  output logic       wren_Zahl1_to_erg_o,
  output logic       wren_term_erg_o,
  output logic       wren_res_to_erg_o,
  output logic       erg_to_alu_a_o,
  output logic       Zahl2_to_alu_b_o,
  output logic       check_for_termination_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output state_t     dbg_state_o
);

  state_t state, state_next;
  logic   wait_load, wait_en, wait_expire;

  ctrl_wait_cnt #(.LAT(ALU_LAT)) u_wait (
    .clk    (clk),
    .rst    (rst),
    .load   (wait_load),
    .en     (wait_en),
    .expire (wait_expire)
  );

  // Reload on every entry into CMP or SUB, including the direct SUB -> CMP hop.
  assign wait_load = (state_next != state) &&
                     ((state_next == ST_CMP) || (state_next == ST_SUB));
  assign wait_en   = (state == ST_CMP) || (state == ST_SUB);

`ifdef CTRL_MODULO_TIMEOUT_EN
  logic [15:0] iter_cnt;
  logic        iter_limit;

  always_ff @(posedge clk) begin
    if (rst) begin
      iter_cnt <= '0;
    end else if (state == ST_LOAD) begin
      iter_cnt <= '0;
    end else if ((state == ST_SUB) && wait_expire) begin
      iter_cnt <= iter_cnt + 16'd1;
    end
  end

  assign iter_limit = (iter_cnt == 16'(MAX_ITER));
`else
  // MAX_ITER has no function without the timeout logic.
  logic unused_max_iter;
  assign unused_max_iter = ^32'(MAX_ITER);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start_i) state_next = ST_CAPT;
      ST_CAPT:  state_next = ST_LOAD;
      ST_LOAD:  state_next = ST_INIT;
      ST_INIT:  state_next = ST_CMP;
      ST_CMP:   if (wait_expire) state_next = ST_CHECK;
      ST_CHECK: begin
        if (valid_i) begin
          state_next = ST_DONE;
`ifdef CTRL_MODULO_TIMEOUT_EN
        end else if (iter_limit) begin
          state_next = ST_ERR;
`endif
        end else begin
          state_next = ST_SUB;
        end
      end
      ST_SUB:   if (wait_expire) state_next = ST_CMP;
      ST_DONE:  state_next = ST_IDLE;
`ifdef CTRL_MODULO_TIMEOUT_EN
      ST_ERR:   state_next = ST_IDLE;
`endif
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    dp_start_o              = 1'b0;
    alu_mode_o              = ALU_NOP;
    wren_update_Zahlen_o    = 1'b0;
    wren_Zahl1_to_erg_o     = 1'b0;
    wren_term_erg_o         = 1'b0;
    wren_res_to_erg_o       = 1'b0;
    erg_to_alu_a_o          = 1'b0;
    Zahl2_to_alu_b_o        = 1'b0;
    check_for_termination_o = 1'b0;
    done_o                  = 1'b0;
    err_o                   = 1'b0;
    case (state)
      ST_CAPT:  dp_start_o = 1'b1;
      ST_LOAD:  wren_update_Zahlen_o = 1'b1;
      ST_INIT:  wren_Zahl1_to_erg_o = 1'b1;
      ST_CMP: begin
        // Operands stay selected through the write-back cycle so the
        // registered ALU result is still the compare of erg and Zahl2.
        alu_mode_o       = ALU_LT;
        erg_to_alu_a_o   = 1'b1;
        Zahl2_to_alu_b_o = 1'b1;
        wren_term_erg_o  = wait_expire;
      end
      ST_CHECK: check_for_termination_o = 1'b1;
      ST_SUB: begin
        alu_mode_o        = ALU_SUB;
        erg_to_alu_a_o    = 1'b1;
        Zahl2_to_alu_b_o  = 1'b1;
        wren_res_to_erg_o = wait_expire;
      end
      ST_DONE:  done_o = 1'b1;
`ifdef CTRL_MODULO_TIMEOUT_EN
      ST_ERR:   err_o = 1'b1;
`endif
      default: ;
    endcase
  end

  assign busy_o      = (state != ST_IDLE);
  assign dbg_state_o = state;

endmodule

// File: tb/tb_controller_modulo.sv
// tb_controller_modulo: bench for controller_modulo with ALU_LAT = 2.
// A small behavioural datapath (operand capture, priority write-back,
// two-stage registered ALU, termination flag) closes the loop around the
// controller so results can be checked against z1 % z2 and done_o timing
// against 6 + ALU_LAT + k*(2*ALU_LAT+3).
module tb_controller_modulo;
  import modulo_pkg::*;

  localparam int ALU_LAT  = 2;
  localparam int MAX_ITER = 4;
`ifdef CTRL_MODULO_TIMEOUT_EN
  localparam int K_LIMIT = MAX_ITER;
`else
  localparam int K_LIMIT = 1000;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic       start_i, valid_i;
  logic       dp_start_o;
  logic [2:0] alu_mode_o;
  logic       wren_update_Zahlen_o, wren_Zahl1_to_erg_o, wren_term_erg_o, wren_res_to_erg_o;
  logic       erg_to_alu_a_o, Zahl2_to_alu_b_o, check_for_termination_o;
  logic       busy_o, done_o, err_o;
  state_t     dbg_state;

  controller_modulo #(.ALU_LAT(ALU_LAT), .MAX_ITER(MAX_ITER)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .start_i                 (start_i),
    .valid_i                 (valid_i),
    .dp_start_o              (dp_start_o),
    .alu_mode_o              (alu_mode_o),
    .wren_update_Zahlen_o    (wren_update_Zahlen_o),
    .wren_Zahl1_to_erg_o     (wren_Zahl1_to_erg_o),
    .wren_term_erg_o         (wren_term_erg_o),
    .wren_res_to_erg_o       (wren_res_to_erg_o),
    .erg_to_alu_a_o          (erg_to_alu_a_o),
    .Zahl2_to_alu_b_o        (Zahl2_to_alu_b_o),
    .check_for_termination_o (check_for_termination_o),
    .busy_o                  (busy_o),
    .done_o                  (done_o),
    .err_o                   (err_o),
    .dbg_state_o             (dbg_state)
  );

  logic [17:0] all_outs;
  assign all_outs = {dp_start_o, alu_mode_o, wren_update_Zahlen_o, wren_Zahl1_to_erg_o,
                     wren_term_erg_o, wren_res_to_erg_o, erg_to_alu_a_o, Zahl2_to_alu_b_o,
                     check_for_termination_o, busy_o, done_o, err_o, dbg_state};

  // ---------------- datapath model ----------------
  logic [15:0] zahl1, zahl2, tmp1, tmp2, z1_r, z2_r, erg, alu_s1, wbb;
  logic        term_r;

  function automatic logic [15:0] alu_f(input logic [2:0] mode, input logic [15:0] a, input logic [15:0] b);
    if (mode == ALU_LT)  return {15'd0, (a < b)};
    if (mode == ALU_SUB) return a - b;
    return 16'd0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      tmp1 <= '0; tmp2 <= '0; z1_r <= '0; z2_r <= '0;
      erg <= '0; alu_s1 <= '0; wbb <= '0; term_r <= 1'b0;
    end else begin
      if (dp_start_o) begin
        tmp1 <= zahl1;
        tmp2 <= zahl2;
      end
      alu_s1 <= alu_f(alu_mode_o, erg_to_alu_a_o ? erg : 16'd0, Zahl2_to_alu_b_o ? z2_r : 16'd0);
      wbb    <= alu_s1;
      if (wren_update_Zahlen_o) begin
        z1_r <= tmp1;
        z2_r <= tmp2;
      end else if (wren_Zahl1_to_erg_o) begin
        erg <= z1_r;
      end else if (wren_term_erg_o) begin
        term_r <= wbb[0];
      end else if (wren_res_to_erg_o) begin
        erg <= wbb;
      end
    end
  end

  assign valid_i = check_for_termination_o & term_r;

  // ---------------- scoreboard ----------------
  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] exp_q[$];   // {expected done cycle, expected result}
  logic [31:0] exp_item;
  int t0 = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int err_cyc = 0;
  int proto_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if ($countones({wren_update_Zahlen_o, wren_Zahl1_to_erg_o, wren_term_erg_o, wren_res_to_erg_o}) > 1)
        proto_err++;
      if (((alu_mode_o != ALU_NOP) != (erg_to_alu_a_o && Zahl2_to_alu_b_o)) ||
          (erg_to_alu_a_o != Zahl2_to_alu_b_o) || (alu_mode_o > ALU_LT))
        proto_err++;
      if (err_o) begin
        err_cnt++;
        err_cyc = cyc - t0;
      end
      if (done_o) begin
        done_cnt++;
        chk("done_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          exp_item = exp_q.pop_front();
          chk("result", int'(erg), int'(exp_item[15:0]));
          chk("done_cycle", cyc - t0, int'(exp_item[31:16]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic int exp_lat(input int k);
    return 6 + ALU_LAT + k * (2 * ALU_LAT + 3);
  endfunction

  task automatic push_exp(input logic [15:0] a, input logic [15:0] b);
    int k;
    k = int'(a) / int'(b);
    exp_q.push_back({16'(exp_lat(k)), 16'(int'(a) % int'(b))});
  endtask

  // Called at a negedge in an IDLE cycle; returns at the negedge of cycle 1.
  task automatic start_run(input logic [15:0] a, input logic [15:0] b, input logic hold);
    zahl1   = a;
    zahl2   = b;
    start_i = 1'b1;
    @(negedge clk);
    t0 = cyc - 1;
    if (!hold) start_i = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int seen;
    int n;
    seen = done_cnt;
    n = 0;
    while (done_cnt == seen && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({name, "_finished"}, int'(done_cnt != seen), 1);
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic [15:0] z1;
    logic [15:0] z2;
  } vec_t;

  vec_t vecs[16];

  initial begin
    vecs[0]  = '{16'd3,     16'd5};
    vecs[1]  = '{16'd17,    16'd5};
    vecs[2]  = '{16'd20,    16'd5};
    vecs[3]  = '{16'd0,     16'd7};
    vecs[4]  = '{16'd5,     16'd5};
    vecs[5]  = '{16'd65535, 16'd65535};
    vecs[6]  = '{16'd7,     16'd1};
    vecs[7]  = '{16'd100,   16'd9};
    vecs[8]  = '{16'd65535, 16'd30000};
    vecs[9]  = '{16'd4,     16'd65535};
    for (int i = 10; i < 16; i++) begin
      int b, q, r;
      b = int'($urandom_range(1, 50));
      q = int'($urandom_range(0, (K_LIMIT < 20) ? K_LIMIT : 20));
      r = int'($urandom_range(0, b - 1));
      vecs[i] = '{16'(q * b + r), 16'(b)};
    end

    rst = 1'b1; start_i = 1'b0; zahl1 = '0; zahl2 = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'(all_outs), 0);
    rst = 1'b0;
    @(negedge clk);

    // Table vectors; each start lands in the IDLE cycle right after done_o.
    for (int i = 0; i < 16; i++) begin
      if (int'(vecs[i].z1) / int'(vecs[i].z2) <= K_LIMIT) begin
        push_exp(vecs[i].z1, vecs[i].z2);
        start_run(vecs[i].z1, vecs[i].z2, 1'b0);
        wait_done("vec", 400);
        @(negedge clk);
        chk("idle_after_done", int'(busy_o), 0);
      end
    end

    // Mid-run reset with start_i held high; the aborted run must not finish.
    @(negedge clk);
    start_run(16'd17, 16'd5, 1'b1);
    repeat (11) @(negedge clk);
    chk("abort_reached_cycle12", cyc - t0, 12);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("outputs_after_rst", int'(all_outs), 0);
    // start_i is still high, so this IDLE cycle is cycle 0 of the restart.
    t0 = cyc;
    push_exp(16'd17, 16'd5);
    wait_done("restart", 200);
    // start_i was still high in the done cycle; it must not have restarted.
    @(negedge clk);
    start_i = 1'b0;
    chk("start_in_done_ignored", int'(busy_o), 0);
    @(negedge clk);

`ifdef CTRL_MODULO_TIMEOUT_EN
    begin
      int err_before, done_before, n;
      err_before  = err_cnt;
      done_before = done_cnt;
      start_run(16'd9, 16'd0, 1'b0);
      n = 0;
      while (err_cnt == err_before && n < 200) begin
        @(negedge clk);
        #1;
        n++;
      end
      chk("timeout_err_seen", int'(err_cnt != err_before), 1);
      chk("timeout_err_cycle", err_cyc, 5 + ALU_LAT + MAX_ITER * (2 * ALU_LAT + 3) + 1);
      @(negedge clk);
      chk("timeout_idle", int'(busy_o), 0);
      repeat (5) @(negedge clk);
      chk("timeout_err_once", err_cnt - err_before, 1);
      chk("timeout_no_done", done_cnt - done_before, 0);
    end
`else
    chk("err_never_high", err_cnt, 0);
`endif

    chk("wren_onehot_and_alu_sel", proto_err, 0);
    chk("scoreboard_drained", int'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
